// File: rtl/packet_pkg.sv
// rtl/packet_pkg.sv - shared constants and state type for the frame parser
package packet_pkg;

   localparam logic [7:0] SYNC      = 8'h7E;
   localparam int         CHK_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      LEN,
      DATA,
      PUSH,
      CHK
   } state_t;

   // States in which a line error or an inter-byte gap aborts the frame
   function automatic logic abortable(state_t s);
      return s inside {ADDR, LEN, DATA, CHK};
   endfunction

endpackage

// File: rtl/packet_receive_if.sv
// rtl/packet_receive_if.sv - byte input from the UART receiver and word output to the write bus
interface packet_receive_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  rcv_stb;
   logic [7:0]            rcv_dat;
   logic                  rcv_err;
   logic                  rcv_rdy;
   logic                  stb;
   logic                  rdy;
   logic [ADDR_WIDTH-1:0] adr;
   logic [DATA_WIDTH-1:0] dat;
   logic                  err;

   modport slave (
      input  rcv_stb, rcv_dat, rcv_err, rdy,
      output rcv_rdy, stb, adr, dat, err
   );

   modport master (
      output rcv_stb, rcv_dat, rcv_err, rdy,
      input  rcv_rdy, stb, adr, dat, err
   );
endinterface

// File: rtl/packet_receive_watchdog.sv
// rtl/packet_receive_watchdog.sv - loadable down-counter flagging an expired interval of CYCLES enabled clocks
module watchdog #(
   parameter int CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(CYCLES + 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = W'(CYCLES);
      else if (en && cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= W'(CYCLES);
      else
         cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == '0);
endmodule

// File: rtl/packet_receive.sv
// rtl/packet_receive.sv - parses SYNC/ADDR/LEN/payload/CHK frames into addressed words with error pulses
module packet_receive
   import packet_pkg::*;
#(
   parameter real BAUDRATE   = 96e2,
   parameter real FREQUENCY  = 100e6,
   parameter int  ADDR_WIDTH = 8,
   parameter int  DATA_WIDTH = 16,
   parameter int  TIMEOUT    = 4
) (
   input logic              clk,
   input logic              rst,
   packet_receive_if.slave  bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LIMIT = $rtoi(TIMEOUT * 10 * FREQUENCY / BAUDRATE);
   localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
   logic [DATA_WIDTH-1:0]  dat_q, dat_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [CHK_WIDTH-1:0]   sum_q, sum_d;
   logic                   pend_q, pend_d;
   logic                   err_q, err_d;

   logic                   rdy_int, accept, expired, abort;
   logic [CHK_WIDTH-1:0]   chk_sum;

   // Ready is gated by reset directly so it is low throughout reset and high right after release
   assign rdy_int = rst && (state_q != PUSH);
   assign accept  = bus.rcv_stb && rdy_int;
   assign abort   = abortable(state_q) && (bus.rcv_err || expired);
   assign chk_sum = sum_q + bus.rcv_dat;

   watchdog #(.CYCLES(LIMIT)) u_gap (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept || state_q == IDLE),
      .en      (abortable(state_q)),
      .expired (expired)
   );

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      pend_d  = pend_q;
      err_d   = 1'b0;
      if (abort) begin
         state_d = IDLE;
         idx_d   = '0;
         pend_d  = 1'b0;
         err_d   = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               idx_d  = '0;
               pend_d = 1'b0;
               if (accept && bus.rcv_dat == SYNC) state_d = ADDR;
            end
            ADDR: if (accept) begin
               adr_d   = ADDR_WIDTH'(bus.rcv_dat);
               sum_d   = bus.rcv_dat;
               state_d = LEN;
            end
            LEN: if (accept) begin
               cnt_d   = bus.rcv_dat;
               sum_d   = chk_sum;
               idx_d   = '0;
               state_d = (bus.rcv_dat == 8'd0) ? CHK : DATA;
            end
            DATA: if (accept) begin
               // Little-endian: each new byte enters at the top and earlier bytes slide down
               dat_d = (dat_q >> 8) | (DATA_WIDTH'(bus.rcv_dat) << (DATA_WIDTH - 8));
               sum_d = chk_sum;
               if (idx_q == IW'(BYTES - 1)) begin
                  idx_d   = '0;
                  state_d = PUSH;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
            PUSH: begin
               pend_d = pend_q || bus.rcv_err;
               if (bus.rdy) begin
                  adr_d = adr_q + ADDR_WIDTH'(1);
                  cnt_d = cnt_q - 8'd1;
                  if (pend_q || bus.rcv_err) begin
                     pend_d  = 1'b0;
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = (cnt_q == 8'd1) ? CHK : DATA;
                  end
               end
            end
            CHK: if (accept) begin
               err_d   = (chk_sum != '0);
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         sum_q   <= '0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   assign bus.rcv_rdy = rdy_int;
   assign bus.stb     = (state_q == PUSH);
   assign bus.adr     = adr_q;
   assign bus.dat     = dat_q;
   assign bus.err     = err_q;
endmodule

// File: tb/tb_packet_receive.sv
// tb/tb_packet_receive.sv - randomized scoreboard bench for the frame parser
module tb_packet_receive;
   localparam int AW   = 8;
   localparam int DW   = 16;
   localparam int NB   = DW / 8;
   localparam int CHAR = 100;   // 10 bit times at 10 clocks per bit

   typedef struct {
      bit            is_err;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   packet_receive_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   packet_receive #(
      .BAUDRATE   (1e5),
      .FREQUENCY  (1e6),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   ev_t        exp_q[$];
   logic [7:0] bq[$];
   int         vectors     = 0;
   int         miscompares = 0;
   int         hold        = 2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s", name);
   endtask

   task automatic exp_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ev_t e;
      e.is_err = 1'b0;
      e.adr    = a;
      e.dat    = d;
      exp_q.push_back(e);
   endtask

   task automatic exp_err();
      ev_t e;
      e.is_err = 1'b1;
      e.adr    = '0;
      e.dat    = '0;
      exp_q.push_back(e);
   endtask

   // Downstream: hold rdy low for 'hold' cycles of every presented word
   int wcnt = 0;
   always @(posedge clk) begin
      #1;
      if (bus.stb) begin
         if (wcnt >= hold) begin
            bus.rdy = 1'b1;
            wcnt    = 0;
         end else begin
            bus.rdy = 1'b0;
            wcnt++;
         end
      end else begin
         bus.rdy = 1'b0;
         wcnt    = 0;
      end
   end

   logic          stb_p = 1'b0, hs_p = 1'b0, err_p = 1'b0;
   logic [AW-1:0] adr_p = '0;
   logic [DW-1:0] dat_p = '0;
   ev_t           mev;
   always @(negedge clk) begin
      if (!rst) begin
         stb_p = 1'b0;
         hs_p  = 1'b0;
         err_p = 1'b0;
      end else begin
         if (bus.stb && stb_p && !hs_p) begin
            check("stb_hold_adr", bus.adr, adr_p);
            check("stb_hold_dat", bus.dat, dat_p);
         end
         if (bus.stb && bus.rdy) begin
            if (exp_q.size() == 0) begin
               fail("unexpected_word");
            end else begin
               mev = exp_q.pop_front();
               if (mev.is_err) fail("word_where_err_expected");
               check("word_adr", bus.adr, mev.adr);
               check("word_dat", bus.dat, mev.dat);
            end
         end
         if (bus.err) begin
            check("err_one_cycle", err_p, 1'b0);
            if (exp_q.size() == 0) begin
               fail("unexpected_err");
            end else begin
               mev = exp_q.pop_front();
               if (!mev.is_err) fail("err_where_word_expected");
            end
         end
         stb_p = bus.stb;
         hs_p  = bus.stb && bus.rdy;
         adr_p = bus.adr;
         dat_p = bus.dat;
         err_p = bus.err;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      bus.rcv_dat = b;
      bus.rcv_stb = 1'b1;
      while (!bus.rcv_rdy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rcv_rdy) fail("send_byte_timeout");
      @(posedge clk);
      #1 bus.rcv_stb = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic send_queue();
      while (bq.size() != 0) send_byte(bq.pop_front());
   endtask

   // Reference frame builder: checksum makes the 8-bit sum of ADDR..CHK zero
   task automatic send_frame(input logic [7:0] a, input int len, input bit bad);
      logic [7:0]    s;
      logic [7:0]    l;
      logic [DW-1:0] w;
      l = 8'(len);
      bq.delete();
      bq.push_back(8'h7E);
      bq.push_back(a);
      bq.push_back(l);
      s = a + l;
      for (int i = 0; i < len; i++) begin
         w = DW'($urandom);
         exp_word(AW'(a + 8'(i)), w);
         for (int k = 0; k < NB; k++) begin
            bq.push_back(w[8*k +: 8]);
            s = s + w[8*k +: 8];
         end
      end
      s = 8'd0 - s;
      if (bad) begin
         s = s + 8'($urandom_range(1, 255));
         exp_err();
      end
      bq.push_back(s);
      send_queue();
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      check("drain_pending_events", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic push_bytes6(input logic [47:0] v);
      bq.delete();
      for (int i = 5; i >= 0; i--) bq.push_back(v[8*i +: 8]);
   endtask

   initial begin
      #900000;
      $display("FAIL global_time_limit");
      $fatal(1, "time limit");
   end

   initial begin
      int n;
      bus.rcv_stb = 1'b0;
      bus.rcv_dat = 8'h00;
      bus.rcv_err = 1'b0;
      bus.rdy     = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_rcv_rdy", bus.rcv_rdy, 1'b0);
      check("reset_stb", bus.stb, 1'b0);
      check("reset_adr", bus.adr, 0);
      check("reset_dat", bus.dat, 0);
      check("reset_err", bus.err, 1'b0);
      rst = 1'b1;
      #1 check("rcv_rdy_after_release", bus.rcv_rdy, 1'b1);

      // Single word
      exp_word(8'h10, 16'h1234);
      push_bytes6(48'h7E_10_01_34_12_A9);
      send_queue();
      drain();

      // Burst with long backpressure and address wrap
      hold = 50;
      send_frame(8'hFF, 2, 1'b0);
      drain();
      hold = 2;

      // Bad checksum still emits the word
      exp_word(8'h10, 16'h1234);
      exp_err();
      push_bytes6(48'h7E_10_01_34_12_00);
      send_queue();
      drain();

      // Garbage before sync, zero-length frame, then a normal frame
      push_bytes6(48'h00_55_7E_20_00_E0);
      send_queue();
      send_frame(8'h42, 1, 1'b0);
      drain();

      // Gap just under the limit is tolerated
      exp_word(8'h10, 16'h1234);
      send_byte(8'h7E);
      send_byte(8'h10);
      repeat (340) @(negedge clk);
      send_byte(8'h01);
      send_byte(8'h34);
      send_byte(8'h12);
      send_byte(8'hA9);
      drain();

      // Gap of TIMEOUT+1 character times aborts
      exp_err();
      send_byte(8'h7E);
      send_byte(8'h10);
      repeat (5 * CHAR) @(negedge clk);
      drain();
      send_frame(8'h55, 2, 1'b0);
      drain();

      // Line error ignored in IDLE, aborts mid-payload
      @(negedge clk) bus.rcv_err = 1'b1;
      @(negedge clk) bus.rcv_err = 1'b0;
      drain();
      exp_err();
      send_byte(8'h7E);
      send_byte(8'h10);
      send_byte(8'h02);
      send_byte(8'h34);
      @(negedge clk) bus.rcv_err = 1'b1;
      @(negedge clk) bus.rcv_err = 1'b0;
      drain();

      // Line error during PUSH is deferred until the word completes
      hold = 20;
      exp_word(8'h30, 16'hBBAA);
      exp_err();
      send_byte(8'h7E);
      send_byte(8'h30);
      send_byte(8'h02);
      send_byte(8'hAA);
      send_byte(8'hBB);
      n = 0;
      while (!bus.stb && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.stb) fail("wait_stb_timeout");
      bus.rcv_err = 1'b1;
      @(negedge clk) bus.rcv_err = 1'b0;
      drain();
      hold = 2;

      // Reset mid-frame, stale bytes afterwards are hunted past
      send_byte(8'h7E);
      send_byte(8'h10);
      send_byte(8'h02);
      send_byte(8'h11);
      @(negedge clk) rst = 1'b0;
      #1;
      check("midreset_rcv_rdy", bus.rcv_rdy, 1'b0);
      check("midreset_stb", bus.stb, 1'b0);
      check("midreset_adr", bus.adr, 0);
      check("midreset_dat", bus.dat, 0);
      check("midreset_err", bus.err, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      send_byte(8'h22);
      send_byte(8'h33);
      send_frame(8'h80, 3, 1'b0);
      drain();

      // Randomized frames with garbage, bad checksums and varying backpressure
      for (int f = 0; f < 30; f++) begin
         logic [7:0] g;
         hold = $urandom_range(0, 5);
         repeat ($urandom_range(0, 2)) begin
            g = 8'($urandom);
            if (g == 8'h7E) g = 8'h7F;
            send_byte(g);
         end
         send_frame(8'($urandom), $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
